// File: rtl/pipeline_run_controller_if.sv
// Control/status bundle between the cpu pipeline and its run controller.
interface pipeline_run_controller_if #(parameter int CNT_W = 32);
  logic             start;
  logic             pause_req;
  logic             step;
  logic             halt_detect;
  logic             overflow;
  logic             retire_valid;
  logic             pipe_enable;
  logic             pc_write_en;
  logic             fetch_squash;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic             done;
  logic             error;

  modport master (
    output start, pause_req, step, halt_detect, overflow, retire_valid,
    input  pipe_enable, pc_write_en, fetch_squash, state, cycle_count,
           instr_count, done, error
  );

  modport slave (
    input  start, pause_req, step, halt_detect, overflow, retire_valid,
    output pipe_enable, pc_write_en, fetch_squash, state, cycle_count,
           instr_count, done, error
  );
endinterface

// File: rtl/pipeline_run_controller.sv
// Run/halt/single-step sequencer: one pipe enable for PC and all stage buffers,
// HALT drain, overflow fault, saturating cycle/retire counters.
module pipeline_run_controller #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                      clock,
  input logic                      reset,
  pipeline_run_controller_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSED = 3'd2,
    STEP   = 3'd3,
    DRAIN  = 3'd4,
    HALTED = 3'd5,
    FAULT  = 3'd6
  } state_t;

  state_t           st;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             active;
  logic             issuing;

  assign issuing = (st == RUN) || (st == STEP);
  assign active  = issuing || (st == DRAIN);

  always_ff @(posedge clock) begin
    if (!reset) begin
      st        <= IDLE;
      drain_cnt <= '0;
      cyc_cnt   <= '0;
      ret_cnt   <= '0;
    end else begin
      if (active) begin
        if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
        if (bus.retire_valid && ret_cnt != '1) ret_cnt <= ret_cnt + CNT_W'(1);
      end
      case (st)
        IDLE:   if (bus.start) st <= RUN;
        RUN, STEP: begin
          if (bus.overflow) st <= FAULT;
          else if (bus.halt_detect) begin
            st        <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
          else if (bus.pause_req || st == STEP) st <= PAUSED;
        end
        PAUSED: begin
          if (bus.start)     st <= RUN;
          else if (bus.step) st <= STEP;
        end
        // Counter was loaded with DRAIN_CYCLES-1, so HALTED follows the last drain cycle.
        DRAIN: begin
          if (bus.overflow)        st <= FAULT;
          else if (drain_cnt == '0) st <= HALTED;
          else                     drain_cnt <= drain_cnt - DW'(1);
        end
        HALTED: st <= HALTED;
        FAULT:  st <= FAULT;
        default: st <= IDLE;
      endcase
    end
  end

  // HALT in ID must stop the PC and bubble IF/ID in the decode cycle itself.
  assign bus.pipe_enable  = active;
  assign bus.pc_write_en  = issuing && !bus.halt_detect;
  assign bus.fetch_squash = (issuing && bus.halt_detect) || (st == DRAIN);
  assign bus.state        = st;
  assign bus.cycle_count  = cyc_cnt;
  assign bus.instr_count  = ret_cnt;
  assign bus.done         = (st == HALTED);
  assign bus.error        = (st == FAULT);
endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: run, pause/step, halt drain,
// overflow fault, reset mid-drain, and counter saturation on a 4-bit instance.
module tb_pipeline_run_controller;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pipeline_run_controller_if #(.CNT_W(32)) bus ();
  pipeline_run_controller_if #(.CNT_W(4))  bus4 ();

  pipeline_run_controller #(.CNT_W(32), .DRAIN_CYCLES(3)) u_dut (
    .clock(clock), .reset(reset), .bus(bus));
  pipeline_run_controller #(.CNT_W(4), .DRAIN_CYCLES(3)) u_dut4 (
    .clock(clock), .reset(reset), .bus(bus4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Outputs sampled mid-low-phase, away from the edge.
  task automatic settle();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 0; bus.pause_req = 0; bus.step = 0;
    bus.halt_detect = 0; bus.overflow = 0; bus.retire_valid = 0;
    bus4.start = 0; bus4.pause_req = 0; bus4.step = 0;
    bus4.halt_detect = 0; bus4.overflow = 0; bus4.retire_valid = 0;
    tick();
    settle();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_cyc", bus.cycle_count, 0);
    chk("rst_ins", bus.instr_count, 0);
    chk("rst_outs", {28'd0, bus.pipe_enable, bus.pc_write_en, bus.done, bus.error}, 0);
    reset = 1'b1;
    tick();

    // Run 10 cycles, retiring in the first 6
    bus.start = 1; tick(); bus.start = 0;
    settle();
    chk("run_state", 32'(bus.state), 1);
    chk("run_pe", 32'(bus.pipe_enable), 1);
    chk("run_pcwe", 32'(bus.pc_write_en), 1);
    bus.retire_valid = 1;
    tick(6);
    bus.retire_valid = 0;
    tick(4);
    settle();
    chk("run_cyc10", bus.cycle_count, 10);
    chk("run_ins6", bus.instr_count, 6);

    // Pause, hold, two single steps three cycles apart
    bus.pause_req = 1; tick();
    settle();
    chk("pause_state", 32'(bus.state), 2);
    chk("pause_pe", 32'(bus.pipe_enable), 0);
    tick(3);
    settle();
    chk("pause_hold", bus.cycle_count, 11);
    bus.step = 1; tick(); bus.step = 0;
    settle();
    chk("step_state", 32'(bus.state), 3);
    chk("step_pe", 32'(bus.pipe_enable), 1);
    tick();
    settle();
    chk("step_back", 32'(bus.state), 2);
    tick();
    bus.step = 1; tick(); bus.step = 0;
    tick();
    settle();
    chk("step2_state", 32'(bus.state), 2);
    chk("step2_cyc", bus.cycle_count, 13);
    bus.pause_req = 0;
    bus.start = 1; bus.step = 1; tick(); bus.start = 0; bus.step = 0;
    settle();
    chk("resume_state", 32'(bus.state), 1);

    // HALT decode in this RUN cycle
    bus.halt_detect = 1;
    #1;
    chk("halt_pcwe", 32'(bus.pc_write_en), 0);
    chk("halt_sq", 32'(bus.fetch_squash), 1);
    chk("halt_pe", 32'(bus.pipe_enable), 1);
    tick(); bus.halt_detect = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_state", 32'(bus.state), 4);
      chk("drain_sq", 32'(bus.fetch_squash), 1);
      chk("drain_pcwe", 32'(bus.pc_write_en), 0);
      tick();
    end
    settle();
    chk("halted_state", 32'(bus.state), 5);
    chk("halted_done", {30'd0, bus.done, bus.error}, 32'h2);
    chk("halted_pe", 32'(bus.pipe_enable), 0);
    chk("halted_cyc", bus.cycle_count, 17);
    bus.start = 1; tick(3); bus.start = 0;
    settle();
    chk("halted_abs", 32'(bus.state), 5);
    chk("halted_frz", bus.cycle_count, 17);
    chk("halted_ins", bus.instr_count, 6);

    // Reset in the middle of DRAIN, with start asserted
    reset = 0; tick(); reset = 1;
    bus.start = 1; tick(); bus.start = 0;
    bus.halt_detect = 1; tick(); bus.halt_detect = 0;
    tick();
    settle();
    chk("mid_drain", 32'(bus.state), 4);
    reset = 0; bus.start = 1; tick();
    settle();
    chk("rd_state", 32'(bus.state), 0);
    chk("rd_cyc", bus.cycle_count, 0);
    chk("rd_ins", bus.instr_count, 0);
    chk("rd_outs", {27'd0, bus.pipe_enable, bus.pc_write_en, bus.fetch_squash,
                    bus.done, bus.error}, 0);
    reset = 1; bus.start = 0; tick();
    settle();
    chk("rd_after", 32'(bus.state), 0);

    // Overflow beats HALT in the same RUN cycle
    bus.start = 1; tick(); bus.start = 0;
    tick(2);
    bus.overflow = 1; bus.halt_detect = 1; tick();
    bus.overflow = 0; bus.halt_detect = 0;
    settle();
    chk("fault_state", 32'(bus.state), 6);
    chk("fault_flags", {30'd0, bus.done, bus.error}, 32'h1);
    chk("fault_pe", {30'd0, bus.pipe_enable, bus.pc_write_en}, 0);
    chk("fault_cyc", bus.cycle_count, 3);
    bus.start = 1; tick(2); bus.start = 0;
    settle();
    chk("fault_abs", 32'(bus.state), 6);
    chk("fault_frz", bus.cycle_count, 3);

    // 4-bit counters saturate at F
    bus4.start = 1; tick(); bus4.start = 0;
    bus4.retire_valid = 1;
    tick(14);
    settle();
    chk("sat_pre", 32'(bus4.cycle_count), 14);
    tick(6);
    settle();
    chk("sat_cyc", 32'(bus4.cycle_count), 15);
    chk("sat_ins", 32'(bus4.instr_count), 15);
    tick(5);
    settle();
    chk("sat_hold_cyc", 32'(bus4.cycle_count), 15);
    chk("sat_hold_ins", 32'(bus4.instr_count), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
